// File: rtl/bip_control.sv
// Control unit for the BIP accumulator processor: two-cycle fetch/execute
// sequencer with instruction decode, program counter and debug cycle counter.
module bip_control #(
  parameter int NB_ADDR    = 11,
  parameter int NB_OPCODE  = 5,
  parameter int NB_OPERAND = 11,
  parameter int NB_INSTR   = 16,
  parameter int NB_COUNT   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [NB_INSTR-1:0]   i_instruction,
  output logic [NB_ADDR-1:0]    o_addr_pm,
  output logic                  o_rd_pm,
  output logic [1:0]            o_SelA,
  output logic                  o_SelB,
  output logic                  o_WrAcc,
  output logic                  o_op,
  output logic                  o_WrRam,
  output logic                  o_RdRam,
  output logic [NB_OPERAND-1:0] o_operand,
  output logic                  o_halt,
  output logic [NB_COUNT-1:0]   o_cycle_count
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

  state_t                state, state_next;
  logic [NB_ADDR-1:0]    pc, pc_next;
  logic [NB_COUNT-1:0]   cycle_count;
  logic [NB_OPCODE-1:0]  opcode;

  assign opcode        = i_instruction[NB_INSTR-1 -: NB_OPCODE];
  assign o_addr_pm     = pc;
  assign o_halt        = (state == HALT);
  assign o_cycle_count = cycle_count;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Counts only active fetch/execute cycles and sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cycle_count <= '0;
    end else if ((state == FETCH || state == EXEC) && cycle_count != '1) begin
      cycle_count <= cycle_count + NB_COUNT'(1);
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    o_rd_pm    = 1'b0;
    o_SelA     = 2'b00;
    o_SelB     = 1'b0;
    o_WrAcc    = 1'b0;
    o_op       = 1'b0;
    o_WrRam    = 1'b0;
    o_RdRam    = 1'b0;
    o_operand  = '0;

    case (state)
      IDLE: begin
        if (i_start) state_next = FETCH;
      end
      FETCH: begin
        o_rd_pm    = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        o_operand = i_instruction[NB_OPERAND-1:0];
        // Undefined opcodes fall through with all controls low, acting as NOP.
        case (opcode)
          OP_STO:  o_WrRam = 1'b1;
          OP_LD:   begin o_WrAcc = 1'b1; o_RdRam = 1'b1; end
          OP_LDI:  begin o_SelA = 2'b01; o_WrAcc = 1'b1; end
          OP_ADD:  begin o_SelA = 2'b10; o_WrAcc = 1'b1; o_RdRam = 1'b1; end
          OP_ADDI: begin o_SelA = 2'b10; o_SelB = 1'b1; o_WrAcc = 1'b1; end
          OP_SUB:  begin o_SelA = 2'b10; o_WrAcc = 1'b1; o_op = 1'b1; o_RdRam = 1'b1; end
          OP_SUBI: begin o_SelA = 2'b10; o_SelB = 1'b1; o_WrAcc = 1'b1; o_op = 1'b1; end
          default: ;
        endcase
        if (opcode == OP_HLT) begin
          state_next = HALT;
        end else begin
          pc_next    = pc + NB_ADDR'(1);
          state_next = FETCH;
        end
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bip_control.sv
// Scoreboard bench for bip_control: directed programs push expected EXEC-cycle
// controls into a queue, and a negedge monitor pops and compares each EXEC cycle.
module tb_bip_control;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_instruction;
  logic [10:0] o_addr_pm;
  logic        o_rd_pm;
  logic [1:0]  o_SelA;
  logic        o_SelB, o_WrAcc, o_op, o_WrRam, o_RdRam;
  logic [10:0] o_operand;
  logic        o_halt;
  logic [31:0] o_cycle_count;

  logic [15:0] pm [0:2047];
  logic [28:0] exp_q [$];
  int          tests = 0;
  int          fails = 0;
  logic        prev_rd = 1'b0;
  logic [28:0] mon_act, mon_exp;
  logic        seen_wrap;

  bip_control dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_instruction(i_instruction),
    .o_addr_pm(o_addr_pm), .o_rd_pm(o_rd_pm), .o_SelA(o_SelA), .o_SelB(o_SelB),
    .o_WrAcc(o_WrAcc), .o_op(o_op), .o_WrRam(o_WrRam), .o_RdRam(o_RdRam),
    .o_operand(o_operand), .o_halt(o_halt), .o_cycle_count(o_cycle_count)
  );

  always #5 i_clk = ~i_clk;

  // Program memory with one cycle of read latency.
  always @(posedge i_clk) begin
    if (o_rd_pm) i_instruction <= pm[o_addr_pm];
  end

  function automatic logic [15:0] enc(input logic [4:0] opc, input logic [10:0] opd);
    return {opc, opd};
  endfunction

  function automatic logic [28:0] exp_vec(input logic [1:0] sel_a, input logic sel_b,
      input logic wr_acc, input logic op, input logic wr_ram, input logic rd_ram,
      input logic [10:0] operand, input logic [10:0] pc);
    return {sel_a, sel_b, wr_acc, op, wr_ram, rd_ram, operand, pc};
  endfunction

  // Monitor: the cycle after a FETCH strobe is an EXEC cycle.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      prev_rd = 1'b0;
    end else begin
      if (prev_rd) begin
        mon_act = {o_SelA, o_SelB, o_WrAcc, o_op, o_WrRam, o_RdRam, o_operand, o_addr_pm};
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL exec_unexpected: got %h, no expected entry queued", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            fails++;
            $display("[TB] FAIL exec: got sel_a/sel_b/wr_acc/op/wr_ram/rd_ram/operand/pc=%h, expected %h",
                     mon_act, mon_exp);
          end
        end
      end
      prev_rd = o_rd_pm;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_all_zero(input string name);
    checkOutput(name, {o_rd_pm, o_SelA, o_SelB, o_WrAcc, o_op, o_WrRam, o_RdRam, o_halt,
                       o_operand, o_addr_pm, 1'b0}, 32'h0);
  endtask

  // Resets the DUT, loads a fresh program and pulses start once.
  task automatic applyStimulus();
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic clear_pm();
    for (int i = 0; i < 2048; i++) pm[i] = 16'h0000;
  endtask

  task automatic wait_halt(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (o_halt) break;
      tick();
    end
    checkOutput(name, {31'd0, o_halt}, 32'd1);
  endtask

  initial begin
    i_rst = 1'b0;
    i_start = 1'b0;
    i_instruction = 16'h0000;
    clear_pm();
    tick();
    tick();
    check_all_zero("reset_outputs");
    checkOutput("reset_count", o_cycle_count, 32'd0);

    // LDI 5 / ADD 3 / SUBI 1 / HLT
    pm[0] = enc(5'b00011, 11'd5);
    pm[1] = enc(5'b00100, 11'd3);
    pm[2] = enc(5'b00111, 11'd1);
    pm[3] = enc(5'b00000, 11'd0);
    exp_q.push_back(exp_vec(2'b01, 0, 1, 0, 0, 0, 11'd5, 11'd0));
    exp_q.push_back(exp_vec(2'b10, 0, 1, 0, 0, 1, 11'd3, 11'd1));
    exp_q.push_back(exp_vec(2'b10, 1, 1, 1, 0, 0, 11'd1, 11'd2));
    exp_q.push_back(exp_vec(2'b00, 0, 0, 0, 0, 0, 11'd0, 11'd3));
    applyStimulus();
    wait_halt("prog_a_halt", 40);
    checkOutput("prog_a_pc", {21'd0, o_addr_pm}, 32'd3);
    checkOutput("prog_a_count", o_cycle_count, 32'd8);
    checkOutput("prog_a_queue_empty", exp_q.size(), 32'd0);

    // Start is ignored while halted.
    i_start = 1'b1;
    tick();
    tick();
    i_start = 1'b0;
    tick();
    checkOutput("halt_hold", {31'd0, o_halt}, 32'd1);
    checkOutput("halt_count_frozen", o_cycle_count, 32'd8);
    checkOutput("halt_pc_frozen", {21'd0, o_addr_pm}, 32'd3);
    checkOutput("halt_no_fetch", {31'd0, o_rd_pm}, 32'd0);

    // STO 7 / LD 7 / HLT
    clear_pm();
    pm[0] = enc(5'b00001, 11'd7);
    pm[1] = enc(5'b00010, 11'd7);
    exp_q.push_back(exp_vec(2'b00, 0, 0, 0, 1, 0, 11'd7, 11'd0));
    exp_q.push_back(exp_vec(2'b00, 0, 1, 0, 0, 1, 11'd7, 11'd1));
    exp_q.push_back(exp_vec(2'b00, 0, 0, 0, 0, 0, 11'd0, 11'd2));
    applyStimulus();
    wait_halt("prog_b_halt", 40);
    checkOutput("prog_b_count", o_cycle_count, 32'd6);
    checkOutput("prog_b_queue_empty", exp_q.size(), 32'd0);

    // Undefined opcode at address 0 behaves as NOP, then HLT at 1.
    clear_pm();
    pm[0] = enc(5'b11111, 11'h155);
    exp_q.push_back(exp_vec(2'b00, 0, 0, 0, 0, 0, 11'h155, 11'd0));
    exp_q.push_back(exp_vec(2'b00, 0, 0, 0, 0, 0, 11'd0, 11'd1));
    applyStimulus();
    wait_halt("prog_c_halt", 40);
    checkOutput("prog_c_pc", {21'd0, o_addr_pm}, 32'd1);
    checkOutput("prog_c_count", o_cycle_count, 32'd4);
    checkOutput("prog_c_queue_empty", exp_q.size(), 32'd0);

    // 2048 x ADDI 1: PC wraps from 2047 to 0.
    for (int i = 0; i < 2048; i++) begin
      pm[i] = enc(5'b00101, 11'd1);
      exp_q.push_back(exp_vec(2'b10, 1, 1, 0, 0, 0, 11'd1, i[10:0]));
    end
    exp_q.push_back(exp_vec(2'b10, 1, 1, 0, 0, 0, 11'd1, 11'd0));
    applyStimulus();
    seen_wrap = 1'b0;
    for (int i = 0; i < 4200; i++) begin
      if (exp_q.size() == 1 && o_rd_pm) begin
        seen_wrap = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("wrap_reached", {31'd0, seen_wrap}, 32'd1);
    checkOutput("wrap_fetch_addr", {21'd0, o_addr_pm}, 32'd0);
    checkOutput("wrap_count", o_cycle_count, 32'd4096);

    // Asynchronous reset mid-run clears everything immediately.
    i_rst = 1'b0;
    #1;
    exp_q.delete();
    check_all_zero("midrun_reset_outputs");
    checkOutput("midrun_reset_count", o_cycle_count, 32'd0);
    tick();
    i_rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_all_zero("post_reset_idle");
    checkOutput("post_reset_count", o_cycle_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bip_control.md
BIP_CONTROL -- requirements
Module: bip_control

Interface
REQ-001 Parameter NB_ADDR, default 11, program-memory address width (PC width).
REQ-002 Parameter NB_OPCODE, default 5, opcode width, instruction bits [15:11].
REQ-003 Parameter NB_OPERAND, default 11, operand width, instruction bits [10:0].
REQ-004 Parameter NB_INSTR, default 16, instruction width.
REQ-005 Parameter NB_COUNT, default 32, cycle-counter width.
REQ-006 One clock, i_clk; reset is asynchronous and active-low, i_rst.
REQ-007 i_clk  in  1  system clock, all state on rising edge.
REQ-008 i_rst  in  1  asynchronous active-low reset.
REQ-009 i_start  in  1  run request, sampled only in IDLE.
REQ-010 i_instruction  in  NB_INSTR  program-memory read data, valid the cycle after o_rd_pm.
REQ-011 o_addr_pm  out  NB_ADDR  program counter (PC) driven to program memory.
REQ-012 o_rd_pm  out  1  program-memory read strobe.
REQ-013 o_SelA  out  2  accumulator source: 00 data memory, 01 sign-extended operand, 10 ALU result.
REQ-014 o_SelB  out  1  ALU operand B: 0 data memory, 1 operand.
REQ-015 o_WrAcc  out  1  accumulator write enable.
REQ-016 o_op  out  1  ALU op: 0 add, 1 subtract.
REQ-017 o_WrRam / o_RdRam  out  1 each  data-memory write/read strobes.
REQ-018 o_operand  out  NB_OPERAND  instruction operand to datapath.
REQ-019 o_halt  out  1  processor halted.
REQ-020 o_cycle_count  out  NB_COUNT  executed-cycle count for debug.

Function
REQ-021 FSM states SHALL be IDLE, FETCH, EXEC, HALT; IDLE->FETCH when i_start=1, else stay.
REQ-022 FETCH SHALL assert o_rd_pm=1 with o_addr_pm=PC for exactly one cycle, then go to EXEC.
REQ-023 EXEC SHALL decode i_instruction combinationally and drive control outputs for exactly one cycle; 2 cycles per instruction.
REQ-024 Decode table (opcode: SelA,SelB,WrAcc,op,WrRam,RdRam): HLT 00000: all 0; STO 00001: 00,0,0,0,1,0; LD 00010: 00,0,1,0,0,1; LDI 00011: 01,0,1,0,0,0; ADD 00100: 10,0,1,0,0,1; ADDI 00101: 10,1,1,0,0,0; SUB 00110: 10,0,1,1,0,1; SUBI 00111: 10,1,1,1,0,0.
REQ-025 Undefined opcodes SHALL behave as NOP: all controls 0, PC advances.
REQ-026 In EXEC, o_operand SHALL equal i_instruction[10:0]; outside EXEC it SHALL be 0.
REQ-027 All control outputs (SelA..RdRam) SHALL be 0 in IDLE, FETCH, HALT.
REQ-028 EXEC with non-HLT opcode: PC <= PC+1 (modulo 2^NB_ADDR, 2047 wraps to 0), next state FETCH.
REQ-029 EXEC with HLT: PC unchanged, next state HALT.
REQ-030 HALT SHALL hold o_halt=1 and ignore i_start; only reset exits HALT.
REQ-031 o_cycle_count SHALL increment once per cycle in FETCH or EXEC, hold in IDLE/HALT, saturate at all-ones.

Reset
REQ-032 i_rst=0 SHALL immediately force state IDLE, PC=0, o_cycle_count=0, o_halt=0, o_rd_pm=0 and all control outputs 0, regardless of state.
REQ-033 Reset deassertion SHALL leave the block in IDLE; execution restarts only on i_start=1.

Verification
REQ-034 Reset: assert i_rst=0 mid-run -> all outputs 0 same cycle, PC=0; release and hold i_start=0 -> stays IDLE, counter 0.
REQ-035 Program {LDI 5, ADD 3, SUBI 1, HLT}, pulse i_start -> EXEC cycles show SelA=01/WrAcc=1/operand=5, then SelA=10/SelB=0/RdRam=1/operand=3, then SelA=10/SelB=1/op=1/operand=1, then o_halt=1 with PC=3, o_cycle_count=8.
REQ-036 STO 7 / LD 7 -> WrRam=1 with operand 7 in one EXEC; RdRam=1, WrAcc=1, SelA=00 in next.
REQ-037 Opcode 11111 at address 0 -> EXEC controls all 0, PC 0->1, FETCH follows.
REQ-038 Program of 2048 ADDI 1 (no HLT) -> after address 2047 EXEC, o_addr_pm=0 in next FETCH.
REQ-039 In HALT, pulse i_start -> no state change, o_halt stays 1, counter frozen.
